// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// ahb_pkg : shared AHB-Lite encodings and debug-manager state type
// Rev 1.0
// ============================================================================
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'b000
  } hburst_t;

  typedef enum logic [2:0] {
    BYTE  = 3'b000,
    HALF  = 3'b001,
    WORD  = 3'b010,
    DWORD = 3'b011
  } hsize_t;

  typedef enum logic [1:0] {
    DBG_IDLE = 2'b00,
    DBG_ADDR = 2'b01,
    DBG_DATA = 2'b10,
    DBG_RESP = 2'b11
  } ahb_dbg_state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_if.sv
`default_nettype none
// ============================================================================
// ahb_if : AHB-Lite signal bundle with manager and subordinate views
// Rev 1.0
// ============================================================================
interface ahb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    HSEL;
  logic [ADDR_WIDTH-1:0]   HADDR;
  logic                    HWRITE;
  logic [2:0]              HSIZE;
  logic [2:0]              HBURST;
  logic [1:0]              HTRANS;
  logic                    HMASTLOCK;
  logic [DATA_WIDTH-1:0]   HWDATA;
  logic [DATA_WIDTH/8-1:0] HWSTRB;
  logic                    HREADY;
  logic                    HRESP;
  logic [DATA_WIDTH-1:0]   HRDATA;

  modport manager (
    output HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HMASTLOCK, HWDATA, HWSTRB,
    input  HREADY, HRESP, HRDATA
  );

  modport subordinate (
    input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HMASTLOCK, HWDATA, HWSTRB,
    output HREADY, HRESP, HRDATA
  );
endinterface
`default_nettype wire

// File: rtl/ahb_strb_gen.sv
`default_nettype none
// ============================================================================
// ahb_strb_gen : byte-lane strobe and legality flags from (size, addr LSBs)
// Rev 1.0
// ============================================================================
module ahb_strb_gen #(
  parameter  int DATA_WIDTH = 32,
  localparam int STRB_W     = DATA_WIDTH / 8,
  localparam int LSB_W      = $clog2(STRB_W)
) (
  input  logic [2:0]        size,
  input  logic [LSB_W-1:0]  addr_lsb,
  output logic [STRB_W-1:0] strb,
  output logic              misaligned,
  output logic              illegal_size
);

  logic [STRB_W-1:0] w_ones;
  logic [LSB_W-1:0]  w_amask;

  always_comb begin
    illegal_size = (int'(size) > LSB_W);
    w_ones  = '0;
    w_amask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      if (i < (1 << size)) w_ones[i] = 1'b1;
    end
    for (int i = 0; i < LSB_W; i++) begin
      if (i < int'(size)) w_amask[i] = 1'b1;
    end
    misaligned = !illegal_size && (|(addr_lsb & w_amask));
    // Only legal, aligned requests get lanes, so nothing shifts off the top.
    strb = (illegal_size || misaligned) ? '0 : (w_ones << addr_lsb);
  end

endmodule
`default_nettype wire

// File: rtl/ahb_debug_manager.sv
`default_nettype none
// ============================================================================
// ahb_debug_manager : single-outstanding AHB-Lite manager for debug requests
// Optional wait-state timeout: define AHB_DBG_TIMEOUT_EN.      Rev 1.0
// ============================================================================
module ahb_debug_manager
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_if.manager                ahbif,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB_W  = $clog2(STRB_W);

  ahb_dbg_state_t        state_q,     state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  hsel_q,      hsel_d;
  htrans_t               htrans_q,    htrans_d;
  logic [ADDR_WIDTH-1:0] haddr_q,     haddr_d;
  logic                  hwrite_q,    hwrite_d;
  logic [2:0]            hsize_q,     hsize_d;
  logic [DATA_WIDTH-1:0] hwdata_q,    hwdata_d;
  logic [STRB_W-1:0]     hwstrb_q,    hwstrb_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic [STRB_W-1:0]     strb_q,      strb_d;

  logic [STRB_W-1:0]     gen_strb;
  logic                  gen_misaligned;
  logic                  gen_illegal_size;

  ahb_strb_gen #(.DATA_WIDTH(DATA_WIDTH)) u_strb_gen (
    .size         (req_size),
    .addr_lsb     (req_addr[LSB_W-1:0]),
    .strb         (gen_strb),
    .misaligned   (gen_misaligned),
    .illegal_size (gen_illegal_size)
  );

`ifdef AHB_DBG_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        stalled;
  assign stalled = ((state_q == DBG_ADDR) || (state_q == DBG_DATA)) && !ahbif.HREADY;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    hsel_d      = hsel_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hwdata_d    = hwdata_q;
    hwstrb_d    = hwstrb_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
`ifdef AHB_DBG_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    unique case (state_q)
      DBG_IDLE: begin
        if (req_valid) begin
          req_ready_d = 1'b0;
          if (gen_illegal_size || gen_misaligned) begin
            state_d     = DBG_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d  = DBG_ADDR;
            hsel_d   = 1'b1;
            htrans_d = NONSEQ;
            haddr_d  = req_addr;
            hwrite_d = req_write;
            hsize_d  = req_size;
            wdata_d  = req_wdata;
            strb_d   = req_write ? gen_strb : '0;
`ifdef AHB_DBG_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end
        end
      end
      DBG_ADDR: begin
        if (ahbif.HREADY) begin
          state_d  = DBG_DATA;
          hsel_d   = 1'b0;
          htrans_d = IDLE;
          hwdata_d = hwrite_q ? wdata_q : '0;
          hwstrb_d = strb_q;
        end
      end
      DBG_DATA: begin
        // HRESP=1 with HREADY=0 is the first error cycle; only the second completes.
        if (ahbif.HREADY) begin
          state_d     = DBG_RESP;
          rsp_valid_d = 1'b1;
          hwdata_d    = '0;
          hwstrb_d    = '0;
          if (ahbif.HRESP) rsp_err_d   = 1'b1;
          else             rsp_rdata_d = hwrite_q ? '0 : ahbif.HRDATA;
        end
      end
      DBG_RESP: begin
        if (rsp_ready) begin
          state_d     = DBG_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
`ifdef AHB_DBG_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end
      end
      default: state_d = DBG_IDLE;
    endcase

`ifdef AHB_DBG_TIMEOUT_EN
    if (stalled) begin
      if (cnt_q == TO_LAST) begin
        state_d       = DBG_RESP;
        hsel_d        = 1'b0;
        htrans_d      = IDLE;
        hwdata_d      = '0;
        hwstrb_d      = '0;
        rsp_valid_d   = 1'b1;
        rsp_err_d     = 1'b1;
        rsp_timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= DBG_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      hsel_q      <= 1'b0;
      htrans_q    <= IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'd0;
      hwdata_q    <= '0;
      hwstrb_q    <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
`ifdef AHB_DBG_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      hsel_q      <= hsel_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      hwstrb_q    <= hwstrb_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
`ifdef AHB_DBG_TIMEOUT_EN
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_err         = rsp_err_q;
  assign rsp_rdata       = rsp_rdata_q;
`ifdef AHB_DBG_TIMEOUT_EN
  assign rsp_timeout     = rsp_timeout_q;
`else
  assign rsp_timeout     = 1'b0;
`endif

  assign ahbif.HSEL      = hsel_q;
  assign ahbif.HTRANS    = htrans_q;
  assign ahbif.HADDR     = haddr_q;
  assign ahbif.HWRITE    = hwrite_q;
  assign ahbif.HSIZE     = hsize_q;
  assign ahbif.HBURST    = SINGLE;
  assign ahbif.HMASTLOCK = 1'b0;
  assign ahbif.HWDATA    = hwdata_q;
  assign ahbif.HWSTRB    = hwstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_debug_manager.sv
`default_nettype none
// ============================================================================
// tb_ahb_debug_manager : directed bench with a transaction-timeline model
// Rev 1.0
// ============================================================================
module tb_ahb_debug_manager;

  localparam int TO = 8;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;

  ahb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ahbif ();

  ahb_debug_manager #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .ahbif(ahbif),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // Model of the transaction in flight: timeline is counted in cycles after the handshake edge.
  logic        m_busy = 1'b0;
  int          m_t, m_aw, m_dw, m_resp_start;
  logic        m_write, m_err, m_legal, m_tocase;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_strb;
  logic        m_exp_err, m_exp_to;
  logic [31:0] m_exp_rd;
  logic [31:0] exp_haddr = 32'h0;
  logic        exp_hwrite = 1'b0;
  logic [2:0]  exp_hsize = 3'd0;

  logic        e_rr, e_rv, e_err, e_to, e_sel;
  logic [1:0]  e_tr;
  logic [31:0] e_rd, e_wd;
  logic [3:0]  e_st;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0d, time %0t)", name, act, exp, m_t, $time);
    end
  endtask

  always @(negedge HCLK) begin
    if (chk_en) begin
      e_rr = 1'b1; e_rv = 1'b0; e_err = 1'b0; e_to = 1'b0; e_rd = 32'h0;
      e_sel = 1'b0; e_tr = 2'b00; e_wd = 32'h0; e_st = 4'h0;
      if (m_busy) begin
        e_rr = 1'b0;
        if (m_t >= m_resp_start) begin
          e_rv = 1'b1; e_err = m_exp_err; e_to = m_exp_to; e_rd = m_exp_rd;
        end else if (m_t <= 1 + m_aw) begin
          e_sel = 1'b1; e_tr = 2'b10;
        end else begin
          e_wd = m_write ? m_wdata : 32'h0;
          e_st = m_strb;
        end
      end
      chk("req_ready",   64'(req_ready),       64'(e_rr));
      chk("rsp_valid",   64'(rsp_valid),       64'(e_rv));
      chk("rsp_err",     64'(rsp_err),         64'(e_err));
      chk("rsp_timeout", 64'(rsp_timeout),     64'(e_to));
      chk("rsp_rdata",   64'(rsp_rdata),       64'(e_rd));
      chk("HSEL",        64'(ahbif.HSEL),      64'(e_sel));
      chk("HTRANS",      64'(ahbif.HTRANS),    64'(e_tr));
      chk("HWDATA",      64'(ahbif.HWDATA),    64'(e_wd));
      chk("HWSTRB",      64'(ahbif.HWSTRB),    64'(e_st));
      chk("HADDR",       64'(ahbif.HADDR),     64'(exp_haddr));
      chk("HWRITE",      64'(ahbif.HWRITE),    64'(exp_hwrite));
      chk("HSIZE",       64'(ahbif.HSIZE),     64'(exp_hsize));
      chk("HBURST",      64'(ahbif.HBURST),    64'(3'b000));
      chk("HMASTLOCK",   64'(ahbif.HMASTLOCK), 64'(1'b0));
    end
  end

  // Subordinate behaviour scripted from the model timeline.
  task automatic drive_sub();
    int k;
    if (m_t <= 1 + m_aw) begin
      ahbif.HREADY = (m_t == 1 + m_aw); ahbif.HRESP = 1'b0; ahbif.HRDATA = 32'hBAD0_0001;
    end else if (m_t <= 2 + m_aw + m_dw) begin
      k = m_t - 2 - m_aw;
      ahbif.HREADY = (k == m_dw);
      ahbif.HRESP  = m_err && (k >= m_dw - 1);
      ahbif.HRDATA = (k == m_dw) ? m_rdata : 32'hBAD0_0002;
    end else begin
      ahbif.HREADY = 1'b1; ahbif.HRESP = 1'b0; ahbif.HRDATA = 32'hBAD0_0003;
    end
  endtask

  // Hand-computed literal expectations for selected cycles.
  task automatic pins(input int id, input int t);
    case (id)
      1: begin
        if (t == 1) begin
          chk("p1_htrans", 64'(ahbif.HTRANS), 64'(2'b10));
          chk("p1_haddr",  64'(ahbif.HADDR),  64'(32'h1000_0004));
        end
        if (t == 2) begin
          chk("p1_hwdata", 64'(ahbif.HWDATA), 64'(32'hDEAD_BEEF));
          chk("p1_hwstrb", 64'(ahbif.HWSTRB), 64'(4'hF));
          chk("p1_htrans_idle", 64'(ahbif.HTRANS), 64'(2'b00));
        end
        if (t == 3) begin
          chk("p1_rsp_valid", 64'(rsp_valid), 64'(1'b1));
          chk("p1_rsp_err",   64'(rsp_err),   64'(1'b0));
        end
      end
      2: begin
        if (t == 3) chk("p2_hwstrb", 64'(ahbif.HWSTRB), 64'(4'h0));
        if (t == 5) begin
          chk("p2_rsp_valid", 64'(rsp_valid), 64'(1'b1));
          chk("p2_rsp_rdata", 64'(rsp_rdata), 64'(32'h1234_0000));
        end
      end
      3: if (t == 4) begin
        chk("p3_rsp_err",     64'(rsp_err),     64'(1'b1));
        chk("p3_rsp_timeout", 64'(rsp_timeout), 64'(1'b0));
        chk("p3_rsp_rdata",   64'(rsp_rdata),   64'(32'h0));
      end
      4: if (t == 1) begin
        chk("p4_rsp_valid", 64'(rsp_valid),  64'(1'b1));
        chk("p4_rsp_err",   64'(rsp_err),    64'(1'b1));
        chk("p4_hsel",      64'(ahbif.HSEL), 64'(1'b0));
      end
      5: begin
`ifdef AHB_DBG_TIMEOUT_EN
        if (t == 9) begin
          chk("p5_rsp_err",     64'(rsp_err),      64'(1'b1));
          chk("p5_rsp_timeout", 64'(rsp_timeout),  64'(1'b1));
          chk("p5_htrans",      64'(ahbif.HTRANS), 64'(2'b00));
        end
`else
        if (t == 13) begin
          chk("p5_rsp_valid", 64'(rsp_valid), 64'(1'b1));
          chk("p5_rsp_err",   64'(rsp_err),   64'(1'b0));
          chk("p5_rsp_rdata", 64'(rsp_rdata), 64'(32'hCAFE_0000));
        end
`endif
      end
      6: if (t == 4 || t == 8) begin
        chk("p6_rsp_valid", 64'(rsp_valid), 64'(1'b1));
        chk("p6_rsp_rdata", 64'(rsp_rdata), 64'(32'h0102_0304));
      end
      7: if (t == -1) begin
        chk("p7_rsp_valid", 64'(rsp_valid),    64'(1'b0));
        chk("p7_req_ready", 64'(req_ready),    64'(1'b1));
        chk("p7_hsel",      64'(ahbif.HSEL),   64'(1'b0));
        chk("p7_haddr",     64'(ahbif.HADDR),  64'(32'h0));
        chk("p7_hwdata",    64'(ahbif.HWDATA), 64'(32'h0));
      end
      8: if (t == 2) chk("p8_hwstrb", 64'(ahbif.HWSTRB), 64'(4'h8));
      default: ;
    endcase
  endtask

  task automatic run_txn(input logic w, input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] wd, input int aw, input int dw, input logic er,
                         input logic [31:0] rd, input int stall, input int rst_at, input int pin_id);
    logic last;
    m_write = w; m_wdata = wd; m_aw = aw; m_dw = dw; m_err = er; m_rdata = rd;
    m_legal = (s <= 3'd2) && ((a % (32'd1 << s)) == 32'd0);
    m_strb  = (w && m_legal) ? 4'(((1 << (1 << s)) - 1) << (a % 4)) : 4'h0;
    m_tocase = 1'b0;
`ifdef AHB_DBG_TIMEOUT_EN
    m_tocase = m_legal && (aw + dw >= TO);
`endif
    if (!m_legal)               m_resp_start = 1;
    else if (m_tocase)          m_resp_start = (aw >= TO) ? TO + 1 : TO + 2;
    else                        m_resp_start = 3 + aw + dw;
    m_exp_err = !m_legal || m_tocase || er;
    m_exp_to  = m_tocase;
    m_exp_rd  = (m_exp_err || w) ? 32'h0 : rd;

    req_valid = 1'b1; req_write = w; req_addr = a; req_size = s; req_wdata = wd;
    rsp_ready = 1'b1;
    @(posedge HCLK); #1;
    if (m_legal) begin exp_haddr = a; exp_hwrite = w; exp_hsize = s; end
    m_busy = 1'b1; m_t = 1;
    // A different request stays offered while busy; it must be ignored.
    req_write = ~w; req_addr = 32'hFFFF_FFF0; req_size = 3'd2; req_wdata = 32'hA5A5_A5A5;
    for (int n = 0; n < 300; n++) begin
      drive_sub();
      rsp_ready = (m_t < m_resp_start) ? 1'b1 : ((m_t - m_resp_start) >= stall);
      pins(pin_id, m_t);
      if (rst_at == m_t) begin
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0; req_valid = 1'b0; m_busy = 1'b0;
        exp_haddr = 32'h0; exp_hwrite = 1'b0; exp_hsize = 3'd0;
        pins(pin_id, -1);
        return;
      end
      last = (m_t >= m_resp_start) && rsp_ready;
      @(posedge HCLK); #1;
      if (last) begin
        m_busy = 1'b0; req_valid = 1'b0;
        ahbif.HREADY = 1'b1; ahbif.HRESP = 1'b0;
        return;
      end
      m_t++;
    end
  endtask

  initial begin
    HRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_size = 3'd0; req_wdata = 32'h0; rsp_ready = 1'b0;
    ahbif.HREADY = 1'b1; ahbif.HRESP = 1'b0; ahbif.HRDATA = 32'h0;
    m_t = 0; m_aw = 0; m_dw = 0; m_resp_start = 1;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    chk("rst_req_ready", 64'(req_ready),    64'(1'b1));
    chk("rst_rsp_valid", 64'(rsp_valid),    64'(1'b0));
    chk("rst_htrans",    64'(ahbif.HTRANS), 64'(2'b00));
    chk("rst_haddr",     64'(ahbif.HADDR),  64'(32'h0));
    chk("rst_hwstrb",    64'(ahbif.HWSTRB), 64'(4'h0));
    chk("rst_rsp_rdata", 64'(rsp_rdata),    64'(32'h0));
    chk_en = 1'b1;

    //       w     addr          size  wdata         aw  dw er    rdata         st rst pin
    run_txn(1'b1, 32'h1000_0004, 3'd2, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0,         0, 0, 1);
    run_txn(1'b0, 32'h1000_0002, 3'd1, 32'h0,         0, 2, 1'b0, 32'h1234_0000, 0, 0, 2);
    repeat (2) @(posedge HCLK);
    #1;
    run_txn(1'b0, 32'h2000_0000, 3'd2, 32'h0,         0, 1, 1'b1, 32'h5555_5555, 0, 0, 3);
    run_txn(1'b1, 32'h1000_0002, 3'd2, 32'h1111_2222, 0, 0, 1'b0, 32'h0,         0, 0, 4);
    run_txn(1'b0, 32'h1000_0008, 3'd3, 32'h0,         0, 0, 1'b0, 32'h6666_6666, 0, 0, 0);
    run_txn(1'b0, 32'h1000_0001, 3'd1, 32'h0,         0, 0, 1'b0, 32'h7777_7777, 2, 0, 0);
    run_txn(1'b1, 32'h3000_0003, 3'd0, 32'hAB00_0000, 0, 0, 1'b0, 32'h0,         0, 0, 8);
    run_txn(1'b1, 32'h3000_0001, 3'd0, 32'h0000_CD00, 1, 1, 1'b0, 32'h0,         0, 0, 0);
    run_txn(1'b1, 32'h3000_0002, 3'd1, 32'h5566_0000, 0, 0, 1'b0, 32'h0,         1, 0, 0);
    run_txn(1'b0, 32'h3000_0010, 3'd2, 32'h0,         2, 0, 1'b0, 32'h89AB_CDEF, 0, 0, 0);
    run_txn(1'b0, 32'h4000_0000, 3'd2, 32'h0,         0, 1, 1'b0, 32'h0102_0304, 4, 0, 6);
    run_txn(1'b0, 32'h5000_0000, 3'd2, 32'h0,        10, 0, 1'b0, 32'hCAFE_0000, 0, 0, 5);
    run_txn(1'b1, 32'h6000_0000, 3'd2, 32'h1122_3344, 0, 2, 1'b0, 32'h0,         0, 3, 7);
    run_txn(1'b0, 32'h7000_0004, 3'd2, 32'h0,         0, 0, 1'b0, 32'h7777_8888, 0, 0, 0);
    repeat (3) @(posedge HCLK);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
